// File: rtl/game_state_src_mux.sv
// Registered pad/ball source selector: local logic vs UART peer, HOST/LOCAL/CLIENT.
// Optional MIRROR_CLIENT_X_EN mirrors the remote ball X in CLIENT mode.
module game_state_src_mux #(
   parameter int X_W          = 11,
   parameter int Y_W          = 10,
   parameter int HOR_PIXELS   = 1024,
   parameter int VER_PIXELS   = 768,
   parameter int BALLSIZE     = 20,
   parameter int PAD_HEIGHT   = 100,
   parameter int MODE_STABLE  = 16,
   parameter int LINK_TIMEOUT = 2**20
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           frame_start,
   input  logic [1:0]     mode_sw,
   input  logic [Y_W-1:0] y_p1_logic,
   input  logic [Y_W-1:0] y_p2_logic,
   input  logic [X_W-1:0] x_ball_logic,
   input  logic [Y_W-1:0] y_ball_logic,
   input  logic           uart_valid,
   input  logic [Y_W-1:0] y_pad_uart,
   input  logic [X_W-1:0] x_ball_uart,
   input  logic [Y_W-1:0] y_ball_uart,
   output logic [Y_W-1:0] y_p1_mux,
   output logic [Y_W-1:0] y_p2_mux,
   output logic [X_W-1:0] x_ball_mux,
   output logic [Y_W-1:0] y_ball_mux,
   output logic [1:0]     mode_active,
   output logic           mode_pending,
   output logic           link_lost
);

   localparam logic [X_W-1:0] X_CTR = X_W'((HOR_PIXELS - BALLSIZE) / 2);
   localparam logic [Y_W-1:0] Y_CTR = Y_W'((VER_PIXELS - BALLSIZE) / 2);
   localparam logic [Y_W-1:0] P_CTR = Y_W'((VER_PIXELS - PAD_HEIGHT) / 2);

   localparam logic [1:0] M_HOST   = 2'd0;
   localparam logic [1:0] M_LOCAL  = 2'd1;
   localparam logic [1:0] M_CLIENT = 2'd2;

   localparam int DB_W = $clog2(MODE_STABLE + 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(MODE_STABLE);
   localparam logic [DB_W-1:0] DB_HIT = DB_W'(MODE_STABLE - 1);

   localparam int WD_W = $clog2(LINK_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(LINK_TIMEOUT);
   localparam logic [WD_W-1:0] WD_PRE = WD_W'(LINK_TIMEOUT - 1);

   typedef enum logic {RUN, PEND} state_t;

   logic [1:0]      sw_s1;
   logic [1:0]      sw_s2;
   logic [1:0]      dec;
   logic [1:0]      dec_q;
   logic [DB_W-1:0] db_cnt;
   logic [1:0]      cand;
   state_t          state;
   logic [Y_W-1:0]  sh_pad;
   logic [X_W-1:0]  sh_x;
   logic [Y_W-1:0]  sh_y;
   logic [WD_W-1:0] wd_cnt;
   logic [Y_W-1:0]  pad_u;
   logic [X_W-1:0]  x_client;
   logic [Y_W-1:0]  p1_n;
   logic [Y_W-1:0]  p2_n;
   logic [X_W-1:0]  xb_n;
   logic [Y_W-1:0]  yb_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1 <= 2'b00;
         sw_s2 <= 2'b00;
      end else begin
         sw_s1 <= mode_sw;
         sw_s2 <= sw_s1;
      end
   end

   always_comb begin
      dec = M_HOST;
      if (sw_s2[1])
         dec = M_CLIENT;
      else if (sw_s2[0])
         dec = M_LOCAL;
   end

   // db_cnt holds how many consecutive edges dec has matched dec_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q  <= M_HOST;
         db_cnt <= DB_MAX;
         cand   <= M_HOST;
      end else if (dec != dec_q) begin
         dec_q  <= dec;
         db_cnt <= DB_W'(1);
         if (MODE_STABLE == 1)
            cand <= dec;
      end else begin
         if (db_cnt != DB_MAX)
            db_cnt <= db_cnt + DB_W'(1);
         if (db_cnt >= DB_HIT)
            cand <= dec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         mode_active  <= M_HOST;
         mode_pending <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (cand != mode_active) begin
                  state        <= PEND;
                  mode_pending <= 1'b1;
               end
            end
            PEND: begin
               if (frame_start) begin
                  mode_active  <= cand;
                  state        <= RUN;
                  mode_pending <= 1'b0;
               end else if (cand == mode_active) begin
                  state        <= RUN;
                  mode_pending <= 1'b0;
               end
            end
            default: begin
               state        <= RUN;
               mode_pending <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_pad <= P_CTR;
         sh_x   <= X_CTR;
         sh_y   <= Y_CTR;
      end else if (uart_valid) begin
         sh_pad <= y_pad_uart;
         sh_x   <= x_ball_uart;
         sh_y   <= y_ball_uart;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt    <= WD_MAX;
         link_lost <= 1'b1;
      end else if (uart_valid) begin
         wd_cnt    <= '0;
         link_lost <= 1'b0;
      end else if (wd_cnt != WD_MAX) begin
         wd_cnt    <= wd_cnt + WD_W'(1);
         link_lost <= (wd_cnt == WD_PRE);
      end else begin
         link_lost <= 1'b1;
      end
   end

`ifdef MIRROR_CLIENT_X_EN
   localparam logic [X_W-1:0] X_MAX = X_W'(HOR_PIXELS - BALLSIZE);
   assign x_client = (sh_x > X_MAX) ? '0 : X_MAX - sh_x;
`else
   assign x_client = sh_x;
`endif

   assign pad_u = link_lost ? P_CTR : sh_pad;

   always_comb begin
      p1_n = y_p1_logic;
      p2_n = pad_u;
      xb_n = x_ball_logic;
      yb_n = y_ball_logic;
      case (mode_active)
         M_LOCAL: begin
            p2_n = y_p2_logic;
         end
         M_CLIENT: begin
            p1_n = pad_u;
            p2_n = y_p1_logic;
            xb_n = x_client;
            yb_n = sh_y;
         end
         default: begin
            p2_n = pad_u;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_p1_mux   <= P_CTR;
         y_p2_mux   <= P_CTR;
         x_ball_mux <= X_CTR;
         y_ball_mux <= Y_CTR;
      end else begin
         y_p1_mux   <= p1_n;
         y_p2_mux   <= p2_n;
         x_ball_mux <= xb_n;
         y_ball_mux <= yb_n;
      end
   end

endmodule

// File: tb/tb_game_state_src_mux.sv
// Directed bench for game_state_src_mux: reset, debounce, mode apply,
// CLIENT/UART path and watchdog, using short MODE_STABLE and LINK_TIMEOUT.
module tb_game_state_src_mux;

   localparam int MS = 4;
   localparam int LT = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic [1:0]  mode_sw;
   logic [9:0]  y_p1_logic;
   logic [9:0]  y_p2_logic;
   logic [10:0] x_ball_logic;
   logic [9:0]  y_ball_logic;
   logic        uart_valid;
   logic [9:0]  y_pad_uart;
   logic [10:0] x_ball_uart;
   logic [9:0]  y_ball_uart;
   logic [9:0]  y_p1_mux;
   logic [9:0]  y_p2_mux;
   logic [10:0] x_ball_mux;
   logic [9:0]  y_ball_mux;
   logic [1:0]  mode_active;
   logic        mode_pending;
   logic        link_lost;

   int checks = 0;
   int failures = 0;
   logic seen;

   game_state_src_mux #(
      .MODE_STABLE (MS),
      .LINK_TIMEOUT(LT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .mode_sw     (mode_sw),
      .y_p1_logic  (y_p1_logic),
      .y_p2_logic  (y_p2_logic),
      .x_ball_logic(x_ball_logic),
      .y_ball_logic(y_ball_logic),
      .uart_valid  (uart_valid),
      .y_pad_uart  (y_pad_uart),
      .x_ball_uart (x_ball_uart),
      .y_ball_uart (y_ball_uart),
      .y_p1_mux    (y_p1_mux),
      .y_p2_mux    (y_p2_mux),
      .x_ball_mux  (x_ball_mux),
      .y_ball_mux  (y_ball_mux),
      .mode_active (mode_active),
      .mode_pending(mode_pending),
      .link_lost   (link_lost)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      frame_start  = 1'b0;
      mode_sw      = 2'b00;
      y_p1_logic   = 10'd100;
      y_p2_logic   = 10'd200;
      x_ball_logic = 11'd300;
      y_ball_logic = 10'd400;
      uart_valid   = 1'b0;
      y_pad_uart   = 10'd0;
      x_ball_uart  = 11'd0;
      y_ball_uart  = 10'd0;

      // T1 reset
      repeat (3) tick();
      chk("rst_x", 32'(x_ball_mux), 502);
      chk("rst_y", 32'(y_ball_mux), 374);
      chk("rst_p1", 32'(y_p1_mux), 334);
      chk("rst_p2", 32'(y_p2_mux), 334);
      chk("rst_mode", 32'(mode_active), 0);
      chk("rst_pend", 32'(mode_pending), 0);
      chk("rst_lost", 32'(link_lost), 1);

      rst_n = 1'b1;
      tick();
      chk("host_p1", 32'(y_p1_mux), 100);
      chk("host_p2_ctr", 32'(y_p2_mux), 334);
      chk("host_x", 32'(x_ball_mux), 300);
      chk("host_y", 32'(y_ball_mux), 400);
      pulse_frame();
      chk("run_fs_mode", 32'(mode_active), 0);
      chk("run_fs_pend", 32'(mode_pending), 0);

      // T2 LOCAL
      mode_sw = 2'b01;
      repeat (MS + 2) tick();
      chk("local_pend_early", 32'(mode_pending), 0);
      tick();
      chk("local_pend", 32'(mode_pending), 1);
      repeat (3) tick();
      chk("local_pend_hold", 32'(mode_pending), 1);
      chk("local_mode_hold", 32'(mode_active), 0);
      pulse_frame();
      chk("local_mode", 32'(mode_active), 1);
      chk("local_pend_clr", 32'(mode_pending), 0);
      chk("local_p2_old", 32'(y_p2_mux), 334);
      tick();
      chk("local_p2", 32'(y_p2_mux), 200);

      // T3 glitch shorter than MODE_STABLE
      mode_sw = 2'b10;
      repeat (MS - 1) tick();
      mode_sw = 2'b01;
      seen = 1'b0;
      repeat (12) begin
         tick();
         if (mode_pending) seen = 1'b1;
      end
      chk("glitch_pend", 32'(seen), 0);
      chk("glitch_mode", 32'(mode_active), 1);

      // T4 CLIENT and UART path
      mode_sw = 2'b10;
      repeat (MS + 3) tick();
      chk("client_pend", 32'(mode_pending), 1);
      pulse_frame();
      chk("client_mode", 32'(mode_active), 2);
      tick();
      chk("client_p1_ctr", 32'(y_p1_mux), 334);
      chk("client_p2", 32'(y_p2_mux), 100);
      chk("client_x_rst", 32'(x_ball_mux), 502);
      chk("client_y_rst", 32'(y_ball_mux), 374);
      uart_valid  = 1'b1;
      y_pad_uart  = 10'd50;
      x_ball_uart = 11'd100;
      y_ball_uart = 10'd60;
      tick();
      uart_valid = 1'b0;
      chk("uart_lost_clr", 32'(link_lost), 0);
      chk("uart_p1_lat1", 32'(y_p1_mux), 334);
      tick();
      chk("uart_p1", 32'(y_p1_mux), 50);
      chk("uart_p2", 32'(y_p2_mux), 100);
      chk("uart_x", 32'(x_ball_mux), 100);
      chk("uart_y", 32'(y_ball_mux), 60);
      y_p1_logic = 10'd123;
      tick();
      chk("client_p2_follow", 32'(y_p2_mux), 123);

      // T5 watchdog
      repeat (LT - 3) tick();
      chk("wd_not_yet", 32'(link_lost), 0);
      tick();
      chk("wd_lost", 32'(link_lost), 1);
      chk("wd_p1_lat", 32'(y_p1_mux), 50);
      tick();
      chk("wd_p1_ctr", 32'(y_p1_mux), 334);
      chk("wd_x_hold", 32'(x_ball_mux), 100);
      chk("wd_y_hold", 32'(y_ball_mux), 60);
      uart_valid  = 1'b1;
      y_pad_uart  = 10'd70;
      x_ball_uart = 11'd110;
      y_ball_uart = 10'd80;
      tick();
      uart_valid = 1'b0;
      chk("wd_relink", 32'(link_lost), 0);
      tick();
      chk("wd_relink_p1", 32'(y_p1_mux), 70);
      chk("wd_relink_x", 32'(x_ball_mux), 110);
      repeat (LT - 2) tick();
      chk("wd_edge_pre", 32'(link_lost), 0);
      uart_valid = 1'b1;
      tick();
      uart_valid = 1'b0;
      chk("wd_valid_wins", 32'(link_lost), 0);

      // T6 async reset while pending
      mode_sw = 2'b01;
      repeat (MS + 3) tick();
      chk("pend_before_rst", 32'(mode_pending), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pend", 32'(mode_pending), 0);
      chk("arst_mode", 32'(mode_active), 0);
      chk("arst_x", 32'(x_ball_mux), 502);
      chk("arst_p1", 32'(y_p1_mux), 334);
      chk("arst_lost", 32'(link_lost), 1);
      tick();
      rst_n = 1'b1;
      pulse_frame();
      chk("arst_fs_mode", 32'(mode_active), 0);
      repeat (MS + 1) tick();
      chk("arst_pend_early", 32'(mode_pending), 0);
      tick();
      chk("arst_pend_again", 32'(mode_pending), 1);
      pulse_frame();
      chk("arst_mode_local", 32'(mode_active), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
